// File: rtl/counter_pkg.sv
// Shared types for the LED counter sequencer: counting modes and FSM states.
package counter_pkg;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DOWN    = 2'd1,
    BOUNCE  = 2'd2,
    ONESHOT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..DIV-1 while run is high and fires tick on the last value.
module tick_gen #(
  parameter int DIV = 125000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  assign tick = run && (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (run) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/stop controller that steps a WIDTH-bit LED count in up, down,
// bounce or one-shot patterns, one step every DIV clock cycles.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 125000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX = '1;

  state_e           state_reg, state_next;
  mode_e            mode_reg, mode_next;
  logic [WIDTH-1:0] leds_reg, leds_next;
  logic             dir_reg, dir_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             run;
  logic             clr;
  logic             tick;
  logic [WIDTH-1:0] step_leds;
  logic             step_dir;
  logic             oneshot_end;

  assign run = (state_reg == RUN);
  assign clr = (state_reg == IDLE) && start && !stop;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .clr  (clr),
    .tick (tick)
  );

  // Value the count takes on the next tick under the latched mode.
  always_comb begin
    step_leds = leds_reg + WIDTH'(1);
    step_dir  = dir_reg;
    case (mode_reg)
      DOWN: step_leds = leds_reg - WIDTH'(1);
      BOUNCE: begin
        if (!dir_reg) begin
          if (leds_reg == MAX) begin
            step_dir  = 1'b1;
            step_leds = MAX - WIDTH'(1);
          end
        end else if (leds_reg == '0) begin
          step_dir  = 1'b0;
          step_leds = WIDTH'(1);
        end else begin
          step_leds = leds_reg - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign oneshot_end = tick && (mode_reg == ONESHOT) && (step_leds == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      mode_reg  <= UP;
      leds_reg  <= '0;
      dir_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      leds_reg  <= leds_next;
      dir_reg   <= dir_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // One-shot completion takes priority over a stop arriving on the same tick.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start && !stop) state_next = RUN;
      RUN: begin
        if (oneshot_end)  state_next = IDLE;
        else if (stop)    state_next = PAUSED;
      end
      PAUSED: begin
        if (stop)         state_next = IDLE;
        else if (start)   state_next = RUN;
      end
      default:            state_next = IDLE;
    endcase
  end

  always_comb begin
    mode_next = mode_reg;
    leds_next = leds_reg;
    dir_next  = dir_reg;
    done_next = 1'b0;
    busy_next = (state_next == RUN);
    unique case (state_reg)
      IDLE: begin
        if (start && !stop) begin
          mode_next = mode_e'(mode);
          leds_next = (mode == DOWN) ? MAX : '0;
          dir_next  = (mode == DOWN);
        end
      end
      RUN: begin
        if (tick) begin
          leds_next = step_leds;
          dir_next  = step_dir;
          done_next = oneshot_end;
        end
      end
      PAUSED: begin
        if (stop) begin
          leds_next = '0;
          dir_next  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign leds = leds_reg;
  assign dir  = dir_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed and randomized checks of counter_sequencer (WIDTH=3, DIV=4) against a step-index model.
module tb_counter_sequencer;

  localparam int WIDTH = 3;
  localparam int DIV   = 4;
  localparam int MAX   = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] leds;
  logic             dir;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  // Model: 0 idle, 1 run, 2 paused; k counts steps since the run began.
  int m_state, m_mode, m_k, m_rc, m_idle_val;
  bit m_done;

  counter_sequencer #(
    .WIDTH(WIDTH),
    .DIV  (DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .stop (stop),
    .mode (mode),
    .leds (leds),
    .dir  (dir),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_leds();
    int p;
    if (m_state == 0) return m_idle_val;
    case (m_mode)
      0: return m_k % (MAX + 1);
      1: return MAX - (m_k % (MAX + 1));
      2: begin
        p = m_k % (2 * MAX);
        return (p <= MAX) ? p : 2 * MAX - p;
      end
      default: return m_k;
    endcase
  endfunction

  function automatic int exp_dir();
    int p;
    if (m_state == 0) return 0;
    if (m_mode == 1) return 1;
    if (m_mode == 2) begin
      p = m_k % (2 * MAX);
      return ((p > MAX) || (p == 0 && m_k > 0)) ? 1 : 0;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_k = 0; m_rc = 0; m_idle_val = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input int md);
    m_done = 0;
    case (m_state)
      0: if (st && !sp) begin
        m_state = 1; m_mode = md; m_k = 0; m_rc = 0;
      end
      1: begin
        m_rc++;
        if (m_rc % DIV == 0) begin
          m_k++;
          if (m_mode == 3 && m_k == MAX) begin
            m_state = 0; m_done = 1; m_idle_val = MAX;
          end
        end
        if (m_state == 1 && sp) m_state = 2;
      end
      default: begin
        if (sp) begin
          m_state = 0; m_idle_val = 0;
        end else if (st) begin
          m_state = 1;
        end
      end
    endcase
  endtask

  task automatic check_all(input string phase);
    check({phase, "_leds"}, 32'(leds), 32'(exp_leds()));
    check({phase, "_dir"},  32'(dir),  32'(exp_dir()));
    check({phase, "_busy"}, 32'(busy), 32'(m_state == 1));
    check({phase, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic cycle(input bit st, input bit sp, input logic [1:0] md, input string phase);
    @(negedge clk);
    start = st; stop = sp; mode = md;
    @(posedge clk);
    model_edge(st, sp, int'(md));
    #1;
    check_all(phase);
  endtask

  task automatic do_reset(input string phase);
    @(negedge clk);
    start = 0; stop = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all({phase, "_async"});
    @(posedge clk);
    #1;
    check_all({phase, "_held"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0; mode = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // UP: steps land every DIV cycles after the sampling edge.
    cycle(1, 0, 2'd0, "up");
    for (int i = 1; i <= 36; i++) begin
      cycle(0, 0, 2'd0, "up");
      if (i % DIV == 0) check("up_step", 32'(leds), 32'((i / DIV) % (MAX + 1)));
    end
    cycle(0, 1, 2'd0, "up_stop");
    cycle(0, 1, 2'd0, "up_clear");

    // BOUNCE over more than a full pass.
    cycle(1, 0, 2'd2, "bounce");
    for (int i = 0; i < 64; i++) cycle(0, 0, 2'd0, "bounce");
    cycle(0, 1, 2'd0, "bounce_stop");
    cycle(0, 1, 2'd0, "bounce_clear");

    // ONESHOT reaches MAX at cycle 28 and then holds in IDLE.
    cycle(1, 0, 2'd3, "oneshot");
    for (int i = 1; i <= 34; i++) begin
      cycle(0, 0, 2'd0, "oneshot");
      if (i == 28) check("oneshot_done28", 32'(done), 32'd1);
    end
    cycle(0, 1, 2'd0, "idle_stop");

    // Pause two cycles after the first step, resume after ten.
    cycle(1, 0, 2'd0, "pause");
    for (int i = 0; i < 5; i++) cycle(0, 0, 2'd0, "pause");
    cycle(0, 1, 2'd0, "pause_stop");
    for (int i = 0; i < 10; i++) cycle(0, 0, 2'd0, "paused");
    cycle(1, 0, 2'd0, "resume");
    cycle(0, 0, 2'd0, "resume1");
    check("resume_hold", 32'(leds), 32'd1);
    cycle(0, 0, 2'd0, "resume2");
    check("resume_step", 32'(leds), 32'd2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 2'd0, "resume");
    cycle(0, 1, 2'd0, "pause2");
    cycle(0, 1, 2'd0, "pause2_clear");
    check("pause2_clear_leds", 32'(leds), 32'd0);

    // start+stop together pauses; start alone in RUN is ignored; mode kept on resume.
    cycle(1, 0, 2'd2, "mix");
    for (int i = 0; i < 9; i++) cycle(i == 5, 0, 2'd1, "mix_startrun");
    cycle(1, 1, 2'd0, "mix_both");
    check("mix_both_busy", 32'(busy), 32'd0);
    cycle(1, 0, 2'd1, "mix_resume");
    for (int i = 0; i < 40; i++) cycle(0, 0, 2'd1, "mix_run");
    cycle(0, 1, 2'd0, "mix_stop");
    cycle(0, 1, 2'd0, "mix_clear");

    // Asynchronous reset mid-run at leds=5.
    cycle(1, 0, 2'd0, "areset");
    for (int i = 0; i < 21; i++) cycle(0, 0, 2'd0, "areset");
    check("areset_pre", 32'(leds), 32'd5);
    do_reset("areset");

    // Randomized pulses and modes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand_reset");
      end else begin
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              2'($urandom_range(0, 3)), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
